// File: rtl/carry_compress_pkg.sv
// Shared definitions for the carry-compression pipeline: mode encoding and
// the per-column count width.
package carry_compress_pkg;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_APPROX = 1'b1
   } mode_e;

   // Bits needed to hold a count of 0..depth.
   function automatic int cw_of(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/carry_compress_column.sv
// One partial-product column: input-side reduction (raw bits or group-OR
// carries, plus lossy flag) and output-side popcount of the registered vector.
module carry_compress_column
   import carry_compress_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GROUP = 2,
   parameter int CW    = cw_of(DEPTH)
) (
   input  logic [DEPTH-1:0] bits_i,
   input  logic             mode_i,
   output logic [DEPTH-1:0] red_o,
   output logic             lossy_o,
   input  logic [DEPTH-1:0] red_q_i,
   output logic [CW-1:0]    count_o
);

   localparam int NG = DEPTH / GROUP;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      red_o   = bits_i;
      lossy_o = 1'b0;
      if (mode_e'(mode_i) == MODE_APPROX) begin
         red_o = '0;
         for (int g = 0; g < NG; g++) begin
            red_o[g] = |bits_i[g*GROUP +: GROUP];
            // Any two set bits in the same group collapse into one carry.
            for (int a = 0; a < GROUP; a++) begin
               for (int b = a + 1; b < GROUP; b++) begin
                  if (bits_i[g*GROUP + a] && bits_i[g*GROUP + b]) lossy_o = 1'b1;
               end
            end
         end
      end
   end

   // Approximate carries sit in the low bits with zeros above, so a plain
   // popcount serves both modes.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_o = count_o + CW'(red_q_i[i]);
      end
   end

endmodule

// File: rtl/carry_compress_pipe.sv
// Two-stage column compressor with valid/ready flow control and a saturating
// counter of lossy approximate beats.
module carry_compress_pipe
   import carry_compress_pkg::*;
#(
   parameter  int COLS  = 8,
   parameter  int DEPTH = 4,
   parameter  int GROUP = 2,
   parameter  int ERRW  = 16,
   localparam int CW    = cw_of(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [COLS*DEPTH-1:0] in_bits,
   input  logic                  mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [COLS*CW-1:0]    out_sum,
   output logic                  out_mode,
   input  logic                  err_clr,
   output logic [ERRW-1:0]       err_cnt
);

   if (GROUP < 2 || GROUP > 4 || (DEPTH % GROUP) != 0) begin : g_bad_group
      $error("carry_compress_pipe: illegal GROUP/DEPTH combination");
   end

   localparam logic [ERRW-1:0] ERR_MAX = '1;

   logic                  s1_valid_q, s2_valid_q;
   logic [COLS*DEPTH-1:0] s1_red_q;
   logic                  s1_mode_q, s2_mode_q;
   logic [COLS*CW-1:0]    s2_sum_q;
   logic [ERRW-1:0]       err_q, err_d;

   logic [COLS*DEPTH-1:0] red_w;
   logic [COLS-1:0]       lossy_w;
   logic [COLS*CW-1:0]    count_w;
   logic                  en1, en2, accept;

   for (genvar c = 0; c < COLS; c++) begin : g_col
      carry_compress_column #(
         .DEPTH (DEPTH),
         .GROUP (GROUP),
         .CW    (CW)
      ) u_col (
         .bits_i  (in_bits[c*DEPTH +: DEPTH]),
         .mode_i  (mode),
         .red_o   (red_w[c*DEPTH +: DEPTH]),
         .lossy_o (lossy_w[c]),
         .red_q_i (s1_red_q[c*DEPTH +: DEPTH]),
         .count_o (count_w[c*CW +: CW])
      );
   end

   // A stage may load when it is empty or its contents leave this cycle.
   assign en2      = !s2_valid_q || out_ready;
   assign en1      = !s1_valid_q || en2;
   assign in_ready = en1;
   assign accept   = in_valid && en1;

   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = '0;
      end else if (accept && (|lossy_w) && err_q != ERR_MAX) begin
         err_d = err_q + ERRW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block evaluation order.
   // NOTE: data registers are reset as well so the outputs read zero after
   // reset, not just the valid flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_red_q   <= '0;
         s1_mode_q  <= MODE_EXACT;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_mode_q  <= MODE_EXACT;
         err_q      <= '0;
      end else begin
         err_q <= err_d;
         if (en1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_red_q  <= red_w;
               s1_mode_q <= mode;
            end
         end
         if (en2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_sum_q  <= count_w;
               s2_mode_q <= s1_mode_q;
            end
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_sum   = s2_sum_q;
   assign out_mode  = s2_mode_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_carry_compress_pipe.sv
// Scoreboard bench for carry_compress_pipe: a driver pushes reference results
// on acceptance, a monitor pops and compares whenever a result is consumed.
module tb_carry_compress_pipe;

   localparam int COLS  = 8;
   localparam int DEPTH = 4;
   localparam int GROUP = 2;
   localparam int ERRW  = 4;
   localparam int CW    = 3;
   localparam int W     = COLS * DEPTH;
   localparam int EMAX  = (1 << ERRW) - 1;

   logic             clk, rst_n;
   logic             in_valid, in_ready, mode, out_valid, out_ready, out_mode, err_clr;
   logic [W-1:0]     in_bits;
   logic [COLS*CW-1:0] out_sum;
   logic [ERRW-1:0]  err_cnt;

   carry_compress_pipe #(
      .COLS (COLS), .DEPTH (DEPTH), .GROUP (GROUP), .ERRW (ERRW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_mode  (out_mode),
      .err_clr   (err_clr),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [COLS*CW-1:0] sum;
      logic               mode;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   err_model = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact = ones per column; approx = non-empty groups per column.
   function automatic exp_t ref_model(input logic [W-1:0] b, input logic m);
      exp_t r;
      r.mode = m;
      r.sum  = '0;
      for (int c = 0; c < COLS; c++) begin
         logic [DEPTH-1:0] col;
         int n;
         col = b[c*DEPTH +: DEPTH];
         n = 0;
         if (!m) n = $countones(col);
         else
            for (int g = 0; g < DEPTH / GROUP; g++) begin
               logic [GROUP-1:0] grp;
               grp = col[g*GROUP +: GROUP];
               if (grp != 0) n++;
            end
         r.sum[c*CW +: CW] = CW'(n);
      end
      return r;
   endfunction

   function automatic bit is_lossy(input logic [W-1:0] b, input logic m);
      bit l;
      l = 1'b0;
      if (m)
         for (int k = 0; k < W / GROUP; k++) begin
            logic [GROUP-1:0] grp;
            grp = b[k*GROUP +: GROUP];
            if ($countones(grp) >= 2) l = 1'b1;
         end
      return l;
   endfunction

   // One clock of stimulus; also checks err_cnt against the model each cycle.
   task automatic drive(input logic v, input logic [W-1:0] b, input logic m,
                        input logic ordy, input logic clr, output bit acc);
      @(negedge clk);
      check("err_cnt", 64'(err_cnt), 64'(err_model));
      in_valid  = v;
      in_bits   = b;
      mode      = m;
      out_ready = ordy;
      err_clr   = clr;
      #3;
      acc = in_valid && in_ready;
      if (acc) q.push_back(ref_model(b, m));
      if (clr) err_model = 0;
      else if (acc && is_lossy(b, m) && err_model < EMAX) err_model++;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
   endtask

   task automatic drain();
      int budget;
      budget = 50;
      while (q.size() != 0 && budget > 0) begin
         idle(1);
         budget--;
      end
      idle(1);
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] rnd_bits();
      return {$urandom, $urandom};
   endfunction

   exp_t mon_e;
   always begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual out_sum=%0h required no beat at %0t", out_sum, $time);
         end else begin
            mon_e = q.pop_front();
            check("out_sum", 64'(out_sum), 64'(mon_e.sum));
            check("out_mode", 64'(out_mode), 64'(mon_e.mode));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int n_acc;
      logic [COLS*CW-1:0] hold_sum;
      logic hold_mode;
      logic [W-1:0] b;

      rst_n = 1'b0; in_valid = 1'b0; in_bits = '0; mode = 1'b0;
      out_ready = 1'b1; err_clr = 1'b0;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum", 64'(out_sum), 64'd0);
      check("rst_out_mode", 64'(out_mode), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exact: column0 = 1011 -> 3, two cycles after acceptance.
      drive(1'b1, W'(4'b1011), 1'b0, 1'b1, 1'b0, acc);
      check("exact_accept", 64'(acc), 64'd1);
      idle(1);
      check("lat_not_yet", 64'(out_valid), 64'd0);
      idle(1);
      check("lat_two", 64'(out_valid), 64'd1);
      check("exact_col0", 64'(out_sum[CW-1:0]), 64'd3);
      idle(1);
      check("exact_no_err", 64'(err_cnt), 64'd0);

      // Approximate: 1011 -> 2 and lossy; 0101 -> 2 and clean.
      drive(1'b1, W'(4'b1011), 1'b1, 1'b1, 1'b0, acc);
      drive(1'b1, W'(4'b0101), 1'b1, 1'b1, 1'b0, acc);
      idle(1);
      check("approx_col0_lossy", 64'(out_sum[CW-1:0]), 64'd2);
      idle(1);
      check("approx_col0_clean", 64'(out_sum[CW-1:0]), 64'd2);
      check("approx_err_one", 64'(err_cnt), 64'd1);
      drain();

      // Backpressure: output stalled, input held valid.
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, rnd_bits(), 1'($urandom), 1'b0, 1'b0, acc);
         if (acc) n_acc++;
      end
      check("bp_accepts", 64'(n_acc), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      hold_sum  = out_sum;
      hold_mode = out_mode;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rnd_bits(), 1'($urandom), 1'b0, 1'b0, acc);
         check("bp_no_accept", 64'(acc), 64'd0);
         check("bp_valid_held", 64'(out_valid), 64'd1);
         check("bp_sum_held", 64'(out_sum), 64'(hold_sum));
         check("bp_mode_held", 64'(out_mode), 64'(hold_mode));
      end
      drain();

      // Saturation at 15 after 17 lossy beats, then clear wins over a lossy beat.
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
      for (int i = 0; i < 17; i++) begin
         b = rnd_bits();
         b[1:0] = 2'b11;
         drive(1'b1, b, 1'b1, 1'b1, 1'b0, acc);
      end
      idle(1);
      check("sat_err", 64'(err_cnt), 64'(EMAX));
      drive(1'b1, W'(4'b0011), 1'b1, 1'b1, 1'b1, acc);
      idle(1);
      check("clr_priority", 64'(err_cnt), 64'd0);
      drain();

      // Alternating mode at full rate.
      n_acc = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, rnd_bits(), 1'(i & 1), 1'b1, 1'b0, acc);
         if (acc) n_acc++;
      end
      check("full_rate_accepts", 64'(n_acc), 64'd40);
      drain();

      // Reset with two beats in flight.
      drive(1'b1, rnd_bits(), 1'b1, 1'b1, 1'b0, acc);
      drive(1'b1, rnd_bits(), 1'b0, 1'b1, 1'b0, acc);
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_err_cnt", 64'(err_cnt), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      err_model = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(6);
      check("midrst_no_stale", 64'(out_valid), 64'd0);

      // Randomized traffic with random backpressure and occasional clears.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), rnd_bits(), 1'($urandom),
               1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0), acc);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/carry_compress_pipe.md
CARRY_COMPRESS_PIPE -- requirements
Module: carry_compress_pipe

Interface
REQ-001 SHALL have parameter COLS, default 8: number of partial-product columns.
REQ-002 SHALL have parameter DEPTH, default 4: bits per column.
REQ-003 SHALL have parameter GROUP, default 2: approximate OR-group size; legal values 2, 3, 4; DEPTH % GROUP == 0.
REQ-004 SHALL have parameter ERRW, default 16: error-counter width.
REQ-005 SHALL derive CW = clog2(DEPTH+1): per-column count width.
REQ-006 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: input beat valid.
REQ-009 SHALL have port in_ready, output, 1: input beat accepted when in_valid & in_ready.
REQ-010 SHALL have port in_bits, input, COLS*DEPTH: column c occupies bits [c*DEPTH +: DEPTH].
REQ-011 SHALL have port mode, input, 1: 0 = exact, 1 = approximate; sampled with the beat.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: result consumed when out_valid & out_ready.
REQ-014 SHALL have port out_sum, output, COLS*CW: column c count at [c*CW +: CW].
REQ-015 SHALL have port out_mode, output, 1: mode of the beat on out_sum.
REQ-016 SHALL have port err_clr, input, 1: synchronous clear of err_cnt.
REQ-017 SHALL have port err_cnt, output, ERRW: saturating count of lossy approximate beats.

Function
REQ-018 SHALL implement two pipeline stages: S1 registers the accepted beat (raw bits or group carries, plus mode); S2 registers per-column counts and mode.
REQ-019 SHALL present the result 2 cycles after acceptance when there is no backpressure; throughput 1 beat/cycle.
REQ-020 SHALL compute stage enables as en2 = !s2_valid | out_ready, en1 = !s1_valid | en2, in_ready = en1; combinational out_ready->in_ready path permitted.
REQ-021 SHALL hold out_sum, out_mode and out_valid stable while out_valid & !out_ready.
REQ-022 SHALL preserve beat order and never drop or duplicate a beat.
REQ-023 SHALL in exact mode output popcount of the column's DEPTH bits (0..DEPTH).
REQ-024 SHALL in approximate mode OR each GROUP-bit slice (group g = bits [g*GROUP +: GROUP]) into one carry and output the number of set carries (0..DEPTH/GROUP).
REQ-025 SHALL define a lossy beat as an accepted approximate beat in which any group of any column has 2 or more bits set.
REQ-026 SHALL increment err_cnt by 1 on the acceptance cycle of each lossy beat, saturating at 2^ERRW-1.
REQ-027 SHALL give err_clr priority: clear and lossy acceptance in the same cycle yields err_cnt = 0.
REQ-028 SHALL ignore in_bits and mode when no beat is accepted.

Reset
REQ-029 SHALL on rst_n low asynchronously clear s1_valid, out_valid, out_sum, out_mode and err_cnt to 0; in-flight beats are discarded.
REQ-030 SHALL drive in_ready = 1 during and after reset, since both stages are empty.

Structure
REQ-031 SHALL place the mode encoding constants (MODE_EXACT = 0, MODE_APPROX = 1) and the CW width function in the shared package carry_compress_pkg.
REQ-032 SHALL implement per-column group-OR and popcount in one sub-module, carry_compress_column, instantiated COLS times.

Verification
REQ-033 SHALL cover exact mode: column0 = 4'b1011, mode = 0 -> out_sum col0 = 3 two cycles later; err_cnt unchanged.
REQ-034 SHALL cover approximate mode: column0 = 4'b1011, mode = 1, GROUP = 2 -> col0 = 2; err_cnt +1. Column0 = 4'b0101 -> col0 = 2 and no error.
REQ-035 SHALL cover backpressure: out_ready = 0 for 5 cycles with in_valid held -> exactly 2 beats accepted, in_ready = 0 thereafter, outputs stable, in-order release once out_ready = 1.
REQ-036 SHALL cover saturation and clear: ERRW = 4, 17 lossy beats -> err_cnt = 15; err_clr together with a lossy beat -> 0.
REQ-037 SHALL cover reset mid-operation: rst_n low with 2 beats in flight -> out_valid = 0 immediately, err_cnt = 0, in_ready = 1; no stale beat after release.
REQ-038 SHALL cover alternating mode per beat at full rate -> out_mode and out_sum match the reference model beat-for-beat.
